// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_pkg
// Brief    : Shared types and helpers for the serial-in parallel-out
//            deserializer (FSM state encoding, default width, counter width).
// Revision : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Receiver FSM states; PARITY is only reachable with SIPO_PARITY_CHK_EN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    localparam int SIPO_DW_DEF = 4;

    // Bit-counter width able to hold the value DW.
    function automatic int sipo_cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : sipo_out_buf
// Brief    : One-entry output register with valid/ready handshake. A word
//            offered while the entry is full and not being drained is
//            dropped and flagged on the sticky overrun output.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_out_buf #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          word_valid,
    input  logic [DW-1:0] word_data,
    input  logic          out_ready,
    input  logic          ovr_clr,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          overrun
);

    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_free;

    // Entry can take a new word if empty or drained at this same edge.
    assign w_free = !r_valid || out_ready;

    // Load on free, otherwise release the entry when the consumer takes it.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (word_valid && w_free) begin
            r_data  <= word_data;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop at the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_overrun <= 1'b0;
        end else if (word_valid && !w_free) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule : sipo_out_buf
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Brief    : Collects an MSB-first serial stream (qualified by in_valid,
//            framed by start) into DW-bit words delivered through a
//            one-entry valid/ready output buffer.
//            Optional macro SIPO_PARITY_CHK_EN adds a trailing even-parity
//            bit per frame; mismatching words are dropped and par_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int DW = SIPO_DW_DEF
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    input  logic          ovr_clr,
    output logic          busy,
    output logic          par_err
);

    localparam int c_cw = sipo_cnt_w(DW);
    localparam logic [c_cw-1:0] c_last = c_cw'(DW - 1);
`ifdef SIPO_PARITY_CHK_EN
    // The full word is parked in the shift register while awaiting parity.
    localparam int c_srw = DW;
`else
    // Only DW-1 bits need storing; the last bit comes straight from in_bit.
    localparam int c_srw = DW - 1;
`endif

    sipo_state_t      r_state;
    logic [c_srw-1:0] r_sr;
    logic [c_cw-1:0]  r_cnt;
    logic             r_busy;
    logic [c_srw-1:0] w_shift;
    logic             w_last;
    logic             w_word_valid;
    logic [DW-1:0]    w_word;

    assign w_shift = c_srw'({r_sr, in_bit});
    assign w_last  = (r_state == RECV) && in_valid && !start && (r_cnt == c_last);

`ifdef SIPO_PARITY_CHK_EN
    logic r_par_err;
    logic w_par_bad;

    assign w_par_bad    = (^r_sr) ^ in_bit;
    assign w_word_valid = (r_state == PARITY) && in_valid && !w_par_bad;
    assign w_word       = r_sr;
    assign par_err      = r_par_err;
`else
    assign w_word_valid = w_last;
    assign w_word       = {r_sr[DW-2:0], in_bit};
    assign par_err      = 1'b0;
`endif

    // Frame FSM: shift register, bit counter and registered busy flag.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
`ifdef SIPO_PARITY_CHK_EN
            r_par_err <= 1'b0;
`endif
        end else begin
`ifdef SIPO_PARITY_CHK_EN
            r_par_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (in_valid && start) begin
                        r_sr    <= w_shift;
                        r_cnt   <= c_cw'(1);
                        r_state <= RECV;
                        r_busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        r_sr <= w_shift;
                        if (start) begin
                            r_cnt <= c_cw'(1);
                        end else if (w_last) begin
                            r_cnt <= '0;
`ifdef SIPO_PARITY_CHK_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + c_cw'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_CHK_EN
                PARITY: begin
                    if (in_valid) begin
                        r_par_err <= w_par_bad;
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    sipo_out_buf #(
        .DW (DW)
    ) u_out_buf (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .word_valid  (w_word_valid),
        .word_data   (w_word),
        .out_ready   (out_ready),
        .ovr_clr     (ovr_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .overrun     (overrun)
    );

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Brief    : Directed self-checking bench for sipo_deserializer (DW=4).
//            Honours SIPO_PARITY_CHK_EN by appending parity bits to frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int DW = 4;

    logic          clk;
    logic          async_rst_n;
    logic          start;
    logic          in_valid;
    logic          in_bit;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          ovr_clr;
    logic          busy;
    logic          par_err;

    int checks = 0;
    int errors = 0;

    sipo_deserializer #(
        .DW (DW)
    ) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .busy        (busy),
        .par_err     (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rise.
    task automatic drive(input logic s, input logic v, input logic b);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // Send one full frame MSB first, plus even parity when enabled.
    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) begin
            drive(i == DW - 1, 1'b1, w[i]);
        end
`ifdef SIPO_PARITY_CHK_EN
        drive(1'b0, 1'b1, ^w);
`endif
    endtask

    initial begin
        async_rst_n = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        out_ready   = 1'b1;
        ovr_clr     = 1'b0;
        #3;
        chk("rst_data",    32'(out_data),  32'h0);
        chk("rst_valid",   32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun),   32'h0);
        chk("rst_busy",    32'(busy),      32'h0);
        chk("rst_par_err", 32'(par_err),   32'h0);
        @(negedge clk);
        async_rst_n = 1'b1;

        // Basic frame 1011 with consumer ready
        drive(1'b1, 1'b1, 1'b1);
        chk("basic_busy_first", 32'(busy),      32'h1);
        chk("basic_valid_early", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
`ifdef SIPO_PARITY_CHK_EN
        chk("basic_busy_parity", 32'(busy),      32'h1);
        chk("basic_valid_parity", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1);
`endif
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_data",  32'(out_data),  32'hB);
        chk("basic_busy_done", 32'(busy),  32'h0);
        drive(1'b0, 1'b0, 1'b0);
        chk("basic_valid_oneshot", 32'(out_valid), 32'h0);

        // Gapped frame: in_bit toggled during gaps must not be shifted
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("gap_busy_a", 32'(busy), 32'h1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        chk("gap_busy_b",  32'(busy),      32'h1);
        chk("gap_valid_b", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
`ifdef SIPO_PARITY_CHK_EN
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
`endif
        chk("gap_valid", 32'(out_valid), 32'h1);
        chk("gap_data",  32'(out_data),  32'hB);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_valid_drain", 32'(out_valid), 32'h0);

        // Backpressure: second word dropped, overrun set, then cleared
        out_ready = 1'b0;
        send_word(4'b1011);
        chk("bp_valid_1",   32'(out_valid), 32'h1);
        chk("bp_data_1",    32'(out_data),  32'hB);
        chk("bp_overrun_1", 32'(overrun),   32'h0);
        send_word(4'b0110);
        chk("bp_valid_2",   32'(out_valid), 32'h1);
        chk("bp_data_2",    32'(out_data),  32'hB);
        chk("bp_overrun_2", 32'(overrun),   32'h1);
        ovr_clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        chk("bp_overrun_clr", 32'(overrun),   32'h0);
        chk("bp_data_hold",   32'(out_data),  32'hB);
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("bp_valid_drain", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-frame while a word is held and overrun set
        out_ready = 1'b0;
        send_word(4'b1011);
        send_word(4'b0110);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        chk("ar_busy_pre",    32'(busy),    32'h1);
        chk("ar_overrun_pre", 32'(overrun), 32'h1);
        @(negedge clk);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("ar_data",    32'(out_data),  32'h0);
        chk("ar_valid",   32'(out_valid), 32'h0);
        chk("ar_overrun", 32'(overrun),   32'h0);
        chk("ar_busy",    32'(busy),      32'h0);
        @(negedge clk);
        async_rst_n = 1'b1;
        out_ready   = 1'b1;
        send_word(4'b0110);
        chk("ar_next_valid", 32'(out_valid), 32'h1);
        chk("ar_next_data",  32'(out_data),  32'h6);
        drive(1'b0, 1'b0, 1'b0);

        // Restart: partial 1,1 abandoned by a new start
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("rs_valid_early", 32'(out_valid), 32'h0);
        drive(1'b0, 1'b1, 1'b1);
`ifdef SIPO_PARITY_CHK_EN
        drive(1'b0, 1'b1, 1'b0);
`endif
        chk("rs_valid",   32'(out_valid), 32'h1);
        chk("rs_data",    32'(out_data),  32'h5);
        chk("rs_overrun", 32'(overrun),   32'h0);
        drive(1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_CHK_EN
        // Bad parity: word dropped, single-cycle par_err, overrun untouched
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        chk("pe_par_err", 32'(par_err),   32'h1);
        chk("pe_valid",   32'(out_valid), 32'h0);
        chk("pe_overrun", 32'(overrun),   32'h0);
        chk("pe_busy",    32'(busy),      32'h0);
        drive(1'b0, 1'b0, 1'b0);
        chk("pe_par_err_pulse", 32'(par_err),   32'h0);
        chk("pe_valid_after",   32'(out_valid), 32'h0);
`else
        chk("np_par_err", 32'(par_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sipo_deserializer
`default_nettype wire
